// File: rtl/dsp_pkg.sv
// dsp_pkg: shared constants and encodings for the fs/4 I/Q correlator.
//   ADC_WIDTH  - bits per ADC sample
//   MAX_POINTS - maximum samples per sweep (power of two)
//   ADDR_W     - capture RAM address width
//   ACC_W      - signed accumulator width
//   state_e    - correlator FSM state encoding
//   phase_e    - fs/4 LO phase encoding (k mod 4)
package dsp_pkg;

  localparam int ADC_WIDTH  = 12;
  localparam int MAX_POINTS = 4096;
  localparam int ADDR_W     = $clog2(MAX_POINTS);
  localparam int ACC_W      = ADC_WIDTH + ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // LO at fs/4: cos = +1,0,-1,0 and -sin = 0,-1,0,+1 over P0..P3.
  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

endpackage

// File: rtl/iq_phase_accum.sv
// iq_phase_accum: one I/Q accumulator pair mixing a sample with the fs/4 LO.
//   clk, rst   - clock, synchronous active-high reset
//   clear      - zero both sums (sweep start)
//   en         - accumulate sample this cycle
//   phase      - LO phase of this sample
//   sample     - sign-extended two's-complement sample
//   i_sum      - in-phase sum
//   q_sum      - quadrature sum
// The LO only takes values +1/0/-1, so each sample is added to, subtracted
// from, or ignored by each sum.
module iq_phase_accum
  import dsp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  phase_e                  phase,
  input  logic signed [ACC_W-1:0] sample,
  output logic signed [ACC_W-1:0] i_sum,
  output logic signed [ACC_W-1:0] q_sum
);

  logic signed [ACC_W-1:0] i_q, i_d;
  logic signed [ACC_W-1:0] q_q, q_d;

  always_comb begin
    i_d = i_q;
    q_d = q_q;
    if (clear) begin
      i_d = '0;
      q_d = '0;
    end else if (en) begin
      case (phase)
        P0:      i_d = i_q + sample;
        P1:      q_d = q_q - sample;
        P2:      i_d = i_q - sample;
        default: q_d = q_q + sample;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      q_q <= '0;
    end else begin
      i_q <= i_d;
      q_q <= q_d;
    end
  end

  assign i_sum = i_q;
  assign q_sum = q_q;

endmodule

// File: rtl/iq_fs4_correlator.sv
// iq_fs4_correlator: sweeps the capture RAM and correlates channels A and B
// against a quadrature LO at fs/4, producing I/Q sums for each channel.
//   clk, rst      - clock, synchronous active-high reset
//   start         - one-cycle request, accepted only in IDLE
//   num_points    - samples to process; 0 or >MAX_POINTS means MAX_POINTS
//   busy          - high from the cycle after acceptance through DONE
//   done          - one-cycle pulse when results are final
//   result_valid  - sticky, set with done, cleared on accept or rst
//   rd_en/rd_addr - RAM read port request
//   rd_data       - {a, b}, registered RAM, one cycle after rd_en
//   i_a,q_a,i_b,q_b - signed correlation sums
//   dbg_state     - current FSM state
// Build option: define IQCORR_OFFSET_BINARY_EN when the ADC words are offset
// binary (MSB is inverted to get two's complement); otherwise the words are
// used directly as two's complement.
//
// Handshake: start is a single-cycle request with no ready; it is honoured
// only while busy=0 and ignored otherwise. done is a single-cycle completion
// pulse; results stay stable until the next accepted start.
module iq_fs4_correlator
  import dsp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W:0]           num_points,
  output logic                      busy,
  output logic                      done,
  output logic                      result_valid,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [2*ADC_WIDTH-1:0]    rd_data,
  output logic signed [ACC_W-1:0]   i_a,
  output logic signed [ACC_W-1:0]   q_a,
  output logic signed [ACC_W-1:0]   i_b,
  output logic signed [ACC_W-1:0]   q_b,
  output logic [1:0]                dbg_state
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic                vld_q, vld_d;
  phase_e              ph_q, ph_d;
  logic                rv_q, rv_d;
  logic                clear;
  logic [ADDR_W:0]     np_m1;
  logic [ADDR_W-1:0]   last_req;

  // Index of the final sample; out-of-range requests clamp to a full sweep.
  always_comb begin
    np_m1 = num_points - (ADDR_W + 1)'(1);
    if ((num_points == '0) || (num_points > (ADDR_W + 1)'(MAX_POINTS))) begin
      last_req = ADDR_W'(MAX_POINTS - 1);
    end else begin
      last_req = np_m1[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    vld_d   = 1'b0;
    ph_d    = ph_q;
    rv_d    = rv_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d  = last_req;
          addr_d  = '0;
          clear   = 1'b1;
          rv_d    = 1'b0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // The phase travels one cycle behind the address to meet the
        // matching RAM word.
        vld_d = 1'b1;
        ph_d  = phase_e'(addr_q[1:0]);
        if (addr_q == last_q) begin
          addr_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        rv_d    = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      vld_q   <= 1'b0;
      ph_q    <= P0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      ph_q    <= ph_d;
      rv_q    <= rv_d;
    end
  end

  // Sample conversion to sign-extended two's complement.
  logic [ADC_WIDTH-1:0]    a_raw, b_raw, a_tc, b_tc;
  logic signed [ACC_W-1:0] a_ext, b_ext;

  always_comb begin
    a_raw = rd_data[2*ADC_WIDTH-1:ADC_WIDTH];
    b_raw = rd_data[ADC_WIDTH-1:0];
`ifdef IQCORR_OFFSET_BINARY_EN
    a_tc = {~a_raw[ADC_WIDTH-1], a_raw[ADC_WIDTH-2:0]};
    b_tc = {~b_raw[ADC_WIDTH-1], b_raw[ADC_WIDTH-2:0]};
`else
    a_tc = a_raw;
    b_tc = b_raw;
`endif
    a_ext = {{ADDR_W{a_tc[ADC_WIDTH-1]}}, a_tc};
    b_ext = {{ADDR_W{b_tc[ADC_WIDTH-1]}}, b_tc};
  end

  iq_phase_accum u_acc_a (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .en     (vld_q),
    .phase  (ph_q),
    .sample (a_ext),
    .i_sum  (i_a),
    .q_sum  (q_a)
  );

  iq_phase_accum u_acc_b (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .en     (vld_q),
    .phase  (ph_q),
    .sample (b_ext),
    .i_sum  (i_b),
    .q_sum  (q_b)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign result_valid = rv_q;
  assign rd_en        = (state_q == ST_READ);
  assign rd_addr      = addr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_iq_fs4_correlator.sv
// Self-checking bench for iq_fs4_correlator with a registered RAM model.
module tb_iq_fs4_correlator;

  logic               clk;
  logic               rst;
  logic               start;
  logic [12:0]        num_points;
  logic               busy;
  logic               done;
  logic               result_valid;
  logic               rd_en;
  logic [11:0]        rd_addr;
  logic [23:0]        rd_data;
  logic signed [23:0] i_a, q_a, i_b, q_b;
  logic [1:0]         dbg_state;

  logic [23:0] mem [0:4095];
  logic [95:0] exp_q[$];

  int n_total;
  int n_pass;

  iq_fs4_correlator dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_points   (num_points),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .i_a          (i_a),
    .q_a          (q_a),
    .i_b          (i_b),
    .q_b          (q_b),
    .dbg_state    (dbg_state)
  );

  // clock / reset / RAM model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // reference model
  function automatic logic signed [23:0] conv(input logic [11:0] w);
    logic [11:0] t;
`ifdef IQCORR_OFFSET_BINARY_EN
    t = {~w[11], w[10:0]};
`else
    t = w;
`endif
    return {{12{t[11]}}, t};
  endfunction

  function automatic logic [95:0] model(input int n);
    logic signed [23:0] ia, qa, ib, qb, xa, xb;
    ia = '0; qa = '0; ib = '0; qb = '0;
    for (int k = 0; k < n; k++) begin
      xa = conv(mem[k][23:12]);
      xb = conv(mem[k][11:0]);
      case (k % 4)
        0: begin ia = ia + xa; ib = ib + xb; end
        1: begin qa = qa - xa; qb = qb - xb; end
        2: begin ia = ia - xa; ib = ib - xb; end
        default: begin qa = qa + xa; qb = qb + xb; end
      endcase
    end
    return {ia, qa, ib, qb};
  endfunction

  // driver: one full sweep, checked against the scoreboard
  task automatic run_sweep(input string name, input int np, input int n_eff,
                           input bit glitch);
    int addr_err;
    int done_cyc;
    logic [95:0] e;
    logic signed [23:0] ei, eq, fi, fq;
    exp_q.push_back(model(n_eff));
    addr_err = 0;
    done_cyc = -1;
    @(posedge clk);
    #1 start = 1'b1; num_points = np[12:0];
    @(posedge clk);  // accept edge t0
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= n_eff + 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_total++;
        if ({busy, result_valid} !== 2'b10)
          $display("FAIL %s accept: busy,result_valid=%b expected 10", name, {busy, result_valid});
        else n_pass++;
      end
      if (cyc <= n_eff) begin
        if (rd_en !== 1'b1 || rd_addr !== 12'(cyc - 1)) begin
          if (addr_err == 0)
            $display("FAIL %s rd_addr at t0+%0d: rd_en=%b addr=%0d expected 1/%0d",
                     name, cyc, rd_en, rd_addr, cyc - 1);
          addr_err++;
        end
      end
      if (glitch && cyc == 2) begin
        start = 1'b1; num_points = 13'd1;
      end
      if (glitch && cyc == 3) start = 1'b0;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    n_total++;
    if (addr_err !== 0) $display("FAIL %s rd_seq: %0d bad cycles expected 0", name, addr_err);
    else n_pass++;
    n_total++;
    if (done_cyc !== n_eff + 2)
      $display("FAIL %s done_time: t0+%0d expected t0+%0d (-1 = timeout)", name, done_cyc, n_eff + 2);
    else n_pass++;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: queue empty expected entry", name);
    end else begin
      e = exp_q.pop_front();
      ei = e[95:72]; eq = e[71:48]; fi = e[47:24]; fq = e[23:0];
      n_total++;
      if (i_a !== ei || q_a !== eq)
        $display("FAIL %s sums_a: i=%0d q=%0d expected i=%0d q=%0d", name, i_a, q_a, ei, eq);
      else n_pass++;
      n_total++;
      if (i_b !== fi || q_b !== fq)
        $display("FAIL %s sums_b: i=%0d q=%0d expected i=%0d q=%0d", name, i_b, q_b, fi, fq);
      else n_pass++;
    end
    n_total++;
    if ({busy, result_valid} !== 2'b11)
      $display("FAIL %s at_done: busy,result_valid=%b expected 11", name, {busy, result_valid});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy, done, result_valid, rd_en} !== 4'b0010)
      $display("FAIL %s after_done: busy,done,rv,rd_en=%b expected 0010", name,
               {busy, done, result_valid, rd_en});
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; num_points = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({busy, done, result_valid, rd_en, rd_addr, dbg_state} !== 18'd0)
      $display("FAIL reset_ctl: busy,done,rv,rd_en,addr,state=%b expected 0",
               {busy, done, result_valid, rd_en, rd_addr, dbg_state});
    else n_pass++;
    n_total++;
    if ({i_a, q_a, i_b, q_b} !== 96'd0)
      $display("FAIL reset_sums: %0d %0d %0d %0d expected 0 0 0 0", i_a, q_a, i_b, q_b);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [11:0] va [4];
    va = '{12'h900, 12'h800, 12'h700, 12'h800};
    for (int k = 0; k < 4; k++) mem[k] = {va[k], 12'h800};
    run_sweep("basic_i", 4, 4, 1'b0);
    va = '{12'h800, 12'h900, 12'h800, 12'h700};
    for (int k = 0; k < 4; k++) mem[k] = {va[k], va[k]};
    run_sweep("basic_q", 4, 4, 1'b0);
  endtask

  task automatic test_full_sweep;
    for (int k = 0; k < 4096; k++) begin
      case (k % 4)
        0: mem[k][23:12] = 12'hFFF;
        2: mem[k][23:12] = 12'h000;
        default: mem[k][23:12] = 12'h800;
      endcase
      mem[k][11:0] = 12'($urandom_range(0, 4095));
    end
    run_sweep("full_n0", 0, 4096, 1'b0);
    for (int k = 0; k < 5; k++) mem[k] = {12'h900, 12'($urandom_range(0, 4095))};
    run_sweep("n5", 5, 5, 1'b0);
    run_sweep("clamp_6000", 6000, 4096, 1'b0);
  endtask

  task automatic test_start_while_busy;
    for (int k = 0; k < 8; k++) mem[k] = 24'($urandom_range(0, 24'hFFFFFF));
    run_sweep("busy_start", 8, 8, 1'b1);
  endtask

  task automatic test_reset_mid;
    @(posedge clk);
    #1 start = 1'b1; num_points = 13'd16;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);  // now in t0+3
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({busy, done, result_valid, rd_en, rd_addr} !== 16'd0 || {i_a, q_a, i_b, q_b} !== 96'd0)
      $display("FAIL reset_mid: busy,done,rv,rd_en,addr=%b sums=%0d,%0d,%0d,%0d expected all 0",
               {busy, done, result_valid, rd_en, rd_addr}, i_a, q_a, i_b, q_b);
    else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) mem[k] = 24'($urandom_range(0, 24'hFFFFFF));
    run_sweep("after_rst", 6, 6, 1'b0);
  endtask

  task automatic test_short;
    mem[0] = {12'h100, 12'hABC};
    run_sweep("n1", 1, 1, 1'b0);
    for (int k = 0; k < 3; k++) mem[k] = {12'hF00, 12'h123};
    run_sweep("n3", 3, 3, 1'b0);
  endtask

  task automatic test_back_to_back;
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 23);
      for (int k = 0; k < n; k++) mem[k] = 24'($urandom_range(0, 24'hFFFFFF));
      run_sweep("rand", n, n, 1'b0);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rd_data = '0;
    test_reset();
    test_basic();
    test_full_sweep();
    test_start_while_busy();
    test_reset_mid();
    test_short();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
